// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port shared by the byte source, the loader and the core.
interface program_loader_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        prog_wr;
  logic [5:0]  prog_addr;
  logic [36:0] prog_data;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [6:0]  words_loaded;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, prog_wr, prog_addr, prog_data, cpu_reset, load_done, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, prog_wr, prog_addr, prog_data, cpu_reset, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/program_loader.sv
// Framed byte-stream boot loader: clears the core memories, writes 37-bit records,
// verifies an XOR checksum and releases the core from reset on a good image.
module program_loader #(
  parameter int         MAX_WORDS      = 64,
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         RST_PULSE      = 2
) (
  input  logic             clk,
  input  logic             reset,
  program_loader_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW = $clog2(RST_PULSE + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, COUNT, RECORD, CHECK, RELEASE, RUN, ERROR} state_e;

  state_e      state_q, state_d;
  logic        rx_ready_q, rx_ready_d;
  logic        prog_wr_q, prog_wr_d;
  logic [5:0]  prog_addr_q, prog_addr_d;
  logic [36:0] prog_data_q, prog_data_d;
  logic        cpu_reset_q, cpu_reset_d;
  logic        load_done_q, load_done_d;
  logic        load_error_q, load_error_d;
  logic [6:0]  words_q, words_d;
  logic [6:0]  nwords_q, nwords_d;
  logic [7:0]  chk_q, chk_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] pulse_q, pulse_d;
  logic [4:0]  op_q;
  logic [23:0] opr_q;

  logic xfer, in_frame, timed_out, bad_count, last_byte, is_start;

  assign xfer      = bus.rx_valid & rx_ready_q;
  assign is_start  = (bus.rx_data == START_BYTE);
  assign in_frame  = (state_q == COUNT) || (state_q == RECORD) || (state_q == CHECK);
  assign timed_out = in_frame && !xfer && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign bad_count = (bus.rx_data == 8'd0) || (bus.rx_data > 8'(MAX_WORDS));
  assign last_byte = (byte_idx_q == 3'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_ready_q   <= 1'b1;
      prog_wr_q    <= 1'b0;
      prog_addr_q  <= '0;
      prog_data_q  <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      words_q      <= '0;
      nwords_q     <= '0;
      chk_q        <= '0;
      byte_idx_q   <= '0;
      tmo_q        <= '0;
      pulse_q      <= '0;
    end else begin
      state_q      <= state_d;
      rx_ready_q   <= rx_ready_d;
      prog_wr_q    <= prog_wr_d;
      prog_addr_q  <= prog_addr_d;
      prog_data_q  <= prog_data_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
      words_q      <= words_d;
      nwords_q     <= nwords_d;
      chk_q        <= chk_d;
      byte_idx_q   <= byte_idx_d;
      tmo_q        <= tmo_d;
      pulse_q      <= pulse_d;
    end
  end

  // Record assembly: byte 0 carries the opcode, bytes 1..3 are held until byte 4 completes the word.
  always_ff @(posedge clk) begin
    if (state_q == RECORD && xfer) begin
      if (byte_idx_q == 3'd0) op_q <= bus.rx_data[4:0];
      else                    opr_q <= {opr_q[15:0], bus.rx_data};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, ERROR: if (xfer && is_start) state_d = CLEAR;
      CLEAR:            if (prog_addr_q == 6'(MAX_WORDS - 1)) state_d = COUNT;
      COUNT:            if (xfer) state_d = bad_count ? ERROR : RECORD;
      RECORD:           if (xfer && last_byte && (words_q + 7'd1 == nwords_q)) state_d = CHECK;
      CHECK:            if (xfer) state_d = (bus.rx_data == chk_q) ? RELEASE : ERROR;
      RELEASE:          if (pulse_q == PW'(RST_PULSE - 1)) state_d = RUN;
      default:          state_d = IDLE;
    endcase
    if (timed_out) state_d = ERROR;
  end

  // Control outputs follow the state being entered, so every output is a plain register.
  always_comb begin
    rx_ready_d   = !((state_d == CLEAR) || (state_d == RELEASE));
    prog_wr_d    = (state_d == CLEAR) || (state_d == COUNT) || (state_d == RECORD) || (state_d == CHECK);
    cpu_reset_d  = (state_d == IDLE) || (state_d == RELEASE) || (state_d == ERROR);
    load_done_d  = (state_d == RUN);
    load_error_d = (state_d == ERROR);
    prog_addr_d  = prog_addr_q;
    prog_data_d  = prog_data_q;
    words_d      = words_q;
    nwords_d     = nwords_q;
    chk_d        = chk_q;
    byte_idx_d   = byte_idx_q;
    tmo_d        = (in_frame && !xfer) ? tmo_q + TW'(1) : '0;
    pulse_d      = (state_q == RELEASE) ? pulse_q + PW'(1) : '0;

    if (state_d == CLEAR && state_q != CLEAR) begin
      prog_addr_d = '0;
      prog_data_d = '0;
      words_d     = '0;
    end else if (state_q == CLEAR && state_d == CLEAR) begin
      prog_addr_d = prog_addr_q + 6'd1;
    end

    if (state_q == COUNT && xfer) begin
      nwords_d   = bus.rx_data[6:0];
      chk_d      = bus.rx_data;
      byte_idx_d = '0;
    end

    if (state_q == RECORD && xfer) begin
      chk_d = chk_q ^ bus.rx_data;
      if (last_byte) begin
        byte_idx_d  = '0;
        prog_addr_d = words_q[5:0];
        prog_data_d = {op_q, opr_q, bus.rx_data};
        words_d     = words_q + 7'd1;
      end else begin
        byte_idx_d  = byte_idx_q + 3'd1;
      end
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.prog_wr      = prog_wr_q;
  assign bus.prog_addr    = prog_addr_q;
  assign bus.prog_data    = prog_data_q;
  assign bus.cpu_reset    = cpu_reset_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Randomized frame bench for program_loader: a frame-level reference model predicts the
// memory image and status; a shadow core memory captures every write the loader makes.
`timescale 1ns/1ps
module tb_program_loader;
  localparam int MAXW = 64;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  logic reset;
  program_loader_if bus();

  program_loader #(.MAX_WORDS(MAXW), .START_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO), .RST_PULSE(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0]  frame_q[$];
  logic [36:0] exp_mem[MAXW];
  logic        exp_done, exp_err;
  int          exp_words;
  logic [36:0] shadow[MAXW];
  int clear_cnt = 0, hi_run = 0, last_hi = 0, scrub_seq = 0, scrub_seen = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behaves as the core's memory plus a few observers of the loader outputs.
  always @(negedge clk) begin
    if (scrub_seq != scrub_seen) begin
      for (int a = 0; a < MAXW; a++) shadow[a] <= 37'h15_A5A5_0000 | 37'(a);
      scrub_seen <= scrub_seq;
    end
    if (!reset) begin
      if (bus.prog_wr) shadow[bus.prog_addr] <= bus.prog_data;
      if (bus.prog_wr && !bus.rx_ready) clear_cnt <= clear_cnt + 1;
      if (bus.cpu_reset) hi_run <= hi_run + 1;
      else begin
        if (hi_run != 0) last_hi <= hi_run;
        hi_run <= 0;
      end
    end
  end

  // Frame-level reference: parse the byte list by the frame rules.
  task automatic model_frame();
    int n;
    logic [7:0] x, b0;
    for (int a = 0; a < MAXW; a++) exp_mem[a] = '0;
    n = int'(frame_q[1]);
    exp_words = 0;
    exp_done = 1'b0;
    exp_err = 1'b1;
    if (n < 1 || n > MAXW) return;
    x = 8'd0;
    for (int i = 1; i < frame_q.size() - 1; i++) x ^= frame_q[i];
    for (int r = 0; r < n; r++) begin
      b0 = frame_q[2 + 5*r];
      exp_mem[r] = {b0[4:0], frame_q[3 + 5*r], frame_q[4 + 5*r], frame_q[5 + 5*r], frame_q[6 + 5*r]};
    end
    exp_words = n;
    exp_done = (x == frame_q[frame_q.size() - 1]);
    exp_err = !exp_done;
  endtask

  task automatic gen_frame(input int kind, input int n);
    logic [7:0] x, b;
    frame_q = {};
    frame_q.push_back(8'hA5);
    if (kind == 2) begin
      b = ($urandom_range(1, 0) == 0) ? 8'd0 : 8'($urandom_range(255, MAXW + 1));
      frame_q.push_back(b);
      return;
    end
    frame_q.push_back(8'(n));
    x = 8'(n);
    for (int i = 0; i < 5*n; i++) begin
      b = 8'($urandom);
      frame_q.push_back(b);
      x ^= b;
    end
    if (kind == 1) x ^= 8'($urandom_range(255, 1));
    frame_q.push_back(x);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
    bus.rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b1;
    bus.rx_data = b;
    waited = 0;
    while (bus.rx_ready !== 1'b1 && waited < 500) begin @(posedge clk); #1; waited++; end
    if (bus.rx_ready !== 1'b1) chk("rx_ready_wait", {63'd0, bus.rx_ready}, 64'd1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic play_frame();
    int w, c0, bad, g;
    model_frame();
    scrub_seq++;
    @(posedge clk); #1;
    c0 = clear_cnt;
    for (int i = 0; i < frame_q.size(); i++) begin
      g = (i < 2) ? 0 : int'($urandom_range(3, 0));
      send_byte(frame_q[i], g, w);
      if (i == 0) chk("done_drop", {63'd0, bus.load_done}, 64'd0);
      if (i == 1) chk("clear_stall", w, 64);
    end
    repeat (6) begin @(posedge clk); #1; end
    chk("load_done", {63'd0, bus.load_done}, {63'd0, exp_done});
    chk("load_error", {63'd0, bus.load_error}, {63'd0, exp_err});
    chk("words_loaded", {57'd0, bus.words_loaded}, exp_words);
    chk("cpu_reset", {63'd0, bus.cpu_reset}, {63'd0, !exp_done});
    chk("prog_wr_idle", {63'd0, bus.prog_wr}, 64'd0);
    chk("clear_writes", clear_cnt - c0, 64);
    bad = 0;
    for (int a = 0; a < MAXW; a++) if (shadow[a] !== exp_mem[a]) bad++;
    chk("mem_image", bad, 0);
    if (exp_done) chk("rst_pulse", last_hi, 2);
  endtask

  function automatic logic [63:0] out_vec();
    return {9'd0, bus.rx_ready, bus.prog_wr, bus.prog_addr, bus.prog_data,
            bus.cpu_reset, bus.load_done, bus.load_error, bus.words_loaded};
  endfunction

  localparam logic [63:0] RESET_VEC = {9'd0, 1'b1, 1'b0, 6'd0, 37'd0, 1'b1, 1'b0, 1'b0, 7'd0};

  task automatic play_literal(input logic [7:0] last);
    frame_q = {8'hA5, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00, 8'h05,
               8'h19, 8'h00, 8'h00, 8'h00, 8'h03, last};
    play_frame();
    chk("lit_addr0", shadow[0], 37'h10_0000_0005);
    chk("lit_addr1", shadow[1], 37'h19_0000_0003);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int w, kind;
    reset = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'd0;
    repeat (3) begin @(posedge clk); #1; end
    chk("reset_state", out_vec(), RESET_VEC);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_state", out_vec(), RESET_VEC);

    play_literal(8'h0D);
    chk("good_done", {63'd0, bus.load_done}, 64'd1);
    play_literal(8'h0C);
    chk("badsum_err", {63'd0, bus.load_error}, 64'd1);

    frame_q = {8'hA5, 8'h00};
    play_frame();
    frame_q = {8'hA5, 8'h41};
    play_frame();

    // Timeout partway through a record.
    send_byte(8'hA5, 0, w);
    send_byte(8'h01, 0, w);
    send_byte(8'h10, 0, w);
    send_byte(8'h00, 0, w);
    repeat (10) begin @(posedge clk); #1; end
    chk("tmo_early", {63'd0, bus.load_error}, 64'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("tmo_error", {63'd0, bus.load_error}, 64'd1);
    chk("tmo_cpu_reset", {63'd0, bus.cpu_reset}, 64'd1);
    play_literal(8'h0D);

    // Maximum-size frame, then reload from RUN.
    gen_frame(0, MAXW);
    play_frame();
    gen_frame(0, 3);
    play_frame();

    // Asynchronous reset after the third operand byte.
    send_byte(8'hA5, 0, w);
    send_byte(8'h01, 0, w);
    send_byte(8'h10, 0, w);
    send_byte(8'h11, 0, w);
    send_byte(8'h22, 0, w);
    send_byte(8'h33, 0, w);
    #2 reset = 1'b1;
    #1 chk("async_reset", out_vec(), RESET_VEC);
    @(posedge clk); #1;
    reset = 1'b0;
    play_literal(8'h0D);

    for (int it = 0; it < 14; it++) begin
      for (int gb = 0; gb < int'($urandom_range(2, 0)); gb++) begin
        logic [7:0] junk;
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, 1, w);
      end
      kind = int'($urandom_range(9, 0));
      gen_frame((kind < 6) ? 0 : (kind < 8) ? 1 : 2, int'($urandom_range(8, 1)));
      play_frame();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
